uart_rx_oversampler: RTL and testbench

Front end of the UART receive path, sitting directly upstream of the receiver control FSM. It synchronises the asynchronous serial line and detects and validates the start bit. It generates one sample strobe at the centre of every bit of the frame (start, DATA_BITS data, parity, stop) and presents the sampled bit plus start/stop qualifiers. Frame format is 1 start bit, DATA_BITS data bits (LSB first), 1 parity bit and 1 stop bit, with the line idle high.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync_edge.sv | 50 +++++
 rtl/uart_rx_oversampler.sv | 178 +++++++++++++++++
 tb/tb_uart_rx_oversampler.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared state encoding, default frame constants and the 2-of-3 vote helper
// for the UART receive front end.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_CHK  = 3'd1,
    DATA       = 3'd2,
    PARITY     = 3'd3,
    STOP       = 3'd4,
    BREAK_WAIT = 3'd5
  } uart_state_e;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 16;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync_edge.sv
// Multi-flop synchroniser for the raw serial line plus a falling-edge pulse
// derived from the synchronised line and its one-cycle-delayed copy.
module uart_sync_edge
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic Clk,
  input  logic reset,
  input  logic rx_i,
  output logic rx_s_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_dly_q;

  // Flops preset high so reset looks like an idle line and never fakes an edge.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      sync_q[0] <= 1'b1;
    end else begin
      sync_q[0] <= rx_i;
    end
  end

  generate
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
          sync_q[gi] <= 1'b1;
        end else begin
          sync_q[gi] <= sync_q[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      rx_dly_q <= 1'b1;
    end else begin
      rx_dly_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rx_s_o = sync_q[SYNC_STAGES-1];
  assign fall_o = rx_dly_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_oversampler.sv
// UART receive front end: start-bit validation and one strobe per bit centre.
// Define UART_RX_MAJORITY_VOTE_EN to sample with a 2-of-3 vote over the last three cycles.
module uart_rx_oversampler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS,
  parameter int SYNC_STAGES  = 2
) (
  input  logic Clk,
  input  logic reset,
  input  logic rx_in,
  output logic bit_strobe_out,
  output logic rx_bit_out,
  output logic start_bit_out,
  output logic stop_bit_out,
  output logic framing_err_out,
  output logic busy_out
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] HALF_TC  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_TC  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  uart_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              strobe_q, strobe_d;
  logic              rx_bit_q, rx_bit_d;
  logic              start_q, start_d;
  logic              stop_q, stop_d;
  logic              ferr_q, ferr_d;
  logic              busy_q, busy_d;
  logic              rx_s;
  logic              fall;
  logic              sample;

  uart_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .Clk   (Clk),
    .reset (reset),
    .rx_i  (rx_in),
    .rx_s_o(rx_s),
    .fall_o(fall)
  );

`ifdef UART_RX_MAJORITY_VOTE_EN
  // hist_q[0] holds rx_s from one cycle back, hist_q[1] from two cycles back.
  logic [1:0] hist_q;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rx_s};
    end
  end

  assign sample = majority3(hist_q[1], hist_q[0], rx_s);
`else
  assign sample = rx_s;
`endif

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      strobe_q <= 1'b0;
      rx_bit_q <= 1'b1;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      strobe_q <= strobe_d;
      rx_bit_q <= rx_bit_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
      ferr_q   <= ferr_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    strobe_d = 1'b0;
    rx_bit_d = rx_bit_q;
    start_d  = 1'b0;
    stop_d   = 1'b0;
    ferr_d   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d = START_CHK;
        end
      end
      START_CHK: begin
        if (cnt_q == HALF_TC) begin
          cnt_d = '0;
          idx_d = '0;
          // A line back high at mid start bit is treated as noise, not a frame.
          if (!sample) begin
            strobe_d = 1'b1;
            start_d  = 1'b1;
            rx_bit_d = 1'b0;
            state_d  = DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == FULL_TC) begin
          cnt_d    = '0;
          strobe_d = 1'b1;
          rx_bit_d = sample;
          idx_d    = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (cnt_q == FULL_TC) begin
          cnt_d    = '0;
          strobe_d = 1'b1;
          rx_bit_d = sample;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (cnt_q == FULL_TC) begin
          cnt_d    = '0;
          strobe_d = 1'b1;
          rx_bit_d = sample;
          if (sample) begin
            stop_d  = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK_WAIT;
          end
        end
      end
      BREAK_WAIT: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bit_strobe_out  = strobe_q;
  assign rx_bit_out      = rx_bit_q;
  assign start_bit_out   = start_q;
  assign stop_bit_out    = stop_q;
  assign framing_err_out = ferr_q;
  assign busy_out        = busy_q;

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Bench for uart_rx_oversampler: frames are driven bit by bit and the strobe
// events expected at each bit centre are predicted from cycle arithmetic.
module tb_uart_rx_oversampler;

  localparam int CPB  = 16;
  localparam int DB   = 8;
  localparam int SYNC = 2;
  localparam int NB   = DB + 3;
  // Negedges from driving the start bit until its strobe is visible.
  localparam int LAT  = 1 + SYNC + CPB / 2;

  typedef struct packed {
    int   cyc;
    logic stb;
    logic b;
    logic st;
    logic sp;
    logic fe;
  } ev_t;

  logic Clk   = 1'b0;
  logic reset = 1'b1;
  logic rx_in = 1'b1;
  logic bit_strobe_out, rx_bit_out, start_bit_out, stop_bit_out, framing_err_out, busy_out;

  int  cyc    = 0;
  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];
  ev_t act_q[$];

  uart_rx_oversampler #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB),
    .SYNC_STAGES (SYNC)
  ) dut (
    .Clk            (Clk),
    .reset          (reset),
    .rx_in          (rx_in),
    .bit_strobe_out (bit_strobe_out),
    .rx_bit_out     (rx_bit_out),
    .start_bit_out  (start_bit_out),
    .stop_bit_out   (stop_bit_out),
    .framing_err_out(framing_err_out),
    .busy_out       (busy_out)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (bit_strobe_out | start_bit_out | stop_bit_out | framing_err_out)
      act_q.push_back(ev_t'{cyc, bit_strobe_out, rx_bit_out, start_bit_out, stop_bit_out, framing_err_out});
  end

  function automatic logic [NB-1:0] make_bits(input logic [7:0] data, input logic par, input logic stp);
    logic [NB-1:0] r;
    r = {stp, par, data[DB-1:0], 1'b0};
    return r;
  endfunction

  // Strobe k of a frame whose start bit is driven at cycle n appears LAT + k*CPB
  // negedges later and reports the line value at the bit centre.
  function automatic void predict(input int n, input logic [NB-1:0] bits, input int gk, input int gj,
                                  input int max_t);
    int   tk;
    logic v;
    for (int k = 0; k < NB; k++) begin
      tk = LAT + CPB * k;
      v  = bits[k];
`ifndef UART_RX_MAJORITY_VOTE_EN
      if (k == gk && gj == CPB / 2) v = ~v;
`endif
      if (tk <= max_t)
        exp_q.push_back(ev_t'{n + tk, 1'b1, v, logic'(k == 0),
                              logic'(k == NB - 1 && bits[NB-1]), logic'(k == NB - 1 && !bits[NB-1])});
    end
  endfunction

  // Must be called right after a negedge; drives max_t cycles of the frame.
  task automatic send_frame(input logic [NB-1:0] bits, input int gk, input int gj, input int max_t);
    int   n;
    logic v;
    n = cyc;
    predict(n, bits, gk, gj, max_t);
    $display("frame bits=%b glitch_bit=%0d glitch_off=%0d start_cycle=%0d", bits, gk, gj, n);
    for (int t = 0; t < max_t; t++) begin
      v = bits[t / CPB];
      if (t / CPB == gk && t % CPB == gj) v = ~v;
      rx_in = v;
      @(negedge Clk);
    end
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge Clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(negedge Clk);
    checks++;
    if ({bit_strobe_out, rx_bit_out, start_bit_out, stop_bit_out, framing_err_out, busy_out} !== 6'b010000) begin
      errors++;
      $display("FAIL reset_held outputs got %b need 010000",
               {bit_strobe_out, rx_bit_out, start_bit_out, stop_bit_out, framing_err_out, busy_out});
    end
    reset = 1'b0;
    repeat (3) @(negedge Clk);
    checks++;
    if ({bit_strobe_out, rx_bit_out, start_bit_out, stop_bit_out, framing_err_out, busy_out} !== 6'b010000) begin
      errors++;
      $display("FAIL reset_released outputs got %b need 010000",
               {bit_strobe_out, rx_bit_out, start_bit_out, stop_bit_out, framing_err_out, busy_out});
    end
  endtask

  task automatic test_frame_a5();
    exp_q.delete();
    act_q.delete();
    fork
      send_frame(make_bits(8'hA5, 1'b0, 1'b1), -1, -1, NB * CPB);
      begin
        repeat (60) @(negedge Clk);
        checks++;
        if (busy_out !== 1'b1) begin
          errors++;
          $display("FAIL a5_busy_mid got %b need 1", busy_out);
        end
      end
    join
    checks++;
    if (busy_out !== 1'b0) begin
      errors++;
      $display("FAIL a5_busy_end got %b need 0", busy_out);
    end
    idle(4);
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL a5_event_count got %0d need %0d", act_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      ev_t a;
      a = (i < act_q.size()) ? act_q[i] : '0;
      checks++;
      if (a !== exp_q[i]) begin
        errors++;
        $display("FAIL a5_event[%0d] got cyc=%0d s/b/st/sp/fe=%b%b%b%b%b need cyc=%0d s/b/st/sp/fe=%b%b%b%b%b", i,
                 a.cyc, a.stb, a.b, a.st, a.sp, a.fe, exp_q[i].cyc, exp_q[i].stb, exp_q[i].b, exp_q[i].st,
                 exp_q[i].sp, exp_q[i].fe);
      end
    end
  endtask

  task automatic test_start_glitch();
    exp_q.delete();
    act_q.delete();
    rx_in = 1'b0;
    repeat (4) @(negedge Clk);
    rx_in = 1'b1;
    checks++;
    if (busy_out !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy_high got %b need 1", busy_out);
    end
    idle(30);
    checks++;
    if (busy_out !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy_low got %b need 0", busy_out);
    end
    checks++;
    if (act_q.size() != 0) begin
      errors++;
      $display("FAIL glitch_event_count got %0d need 0", act_q.size());
    end
  endtask

  task automatic test_framing_error();
    exp_q.delete();
    act_q.delete();
    send_frame(make_bits(8'h3C, 1'b0, 1'b0), -1, -1, NB * CPB);
    repeat (20) @(negedge Clk);
    checks++;
    if (busy_out !== 1'b1) begin
      errors++;
      $display("FAIL ferr_busy_break got %b need 1", busy_out);
    end
    repeat (20) @(negedge Clk);
    idle(10);
    checks++;
    if (busy_out !== 1'b0) begin
      errors++;
      $display("FAIL ferr_busy_after got %b need 0", busy_out);
    end
    send_frame(make_bits(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1), -1, -1, NB * CPB);
    idle(4);
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL ferr_event_count got %0d need %0d", act_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      ev_t a;
      a = (i < act_q.size()) ? act_q[i] : '0;
      checks++;
      if (a !== exp_q[i]) begin
        errors++;
        $display("FAIL ferr_event[%0d] got cyc=%0d s/b/st/sp/fe=%b%b%b%b%b need cyc=%0d s/b/st/sp/fe=%b%b%b%b%b", i,
                 a.cyc, a.stb, a.b, a.st, a.sp, a.fe, exp_q[i].cyc, exp_q[i].stb, exp_q[i].b, exp_q[i].st,
                 exp_q[i].sp, exp_q[i].fe);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_q.delete();
    act_q.delete();
    send_frame(make_bits(8'h00, 1'b0, 1'b1), -1, -1, NB * CPB);
    send_frame(make_bits(8'hFF, 1'b0, 1'b1), -1, -1, NB * CPB);
    idle(4);
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_event_count got %0d need %0d", act_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      ev_t a;
      a = (i < act_q.size()) ? act_q[i] : '0;
      checks++;
      if (a !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_event[%0d] got cyc=%0d s/b/st/sp/fe=%b%b%b%b%b need cyc=%0d s/b/st/sp/fe=%b%b%b%b%b", i,
                 a.cyc, a.stb, a.b, a.st, a.sp, a.fe, exp_q[i].cyc, exp_q[i].stb, exp_q[i].b, exp_q[i].st,
                 exp_q[i].sp, exp_q[i].fe);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    exp_q.delete();
    act_q.delete();
    // Stops on the negedge where the fifth strobe is visible.
    send_frame(make_bits(8'h6B, 1'b1, 1'b1), -1, -1, LAT + 4 * CPB);
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({bit_strobe_out, rx_bit_out, start_bit_out, stop_bit_out, framing_err_out, busy_out} !== 6'b010000) begin
      errors++;
      $display("FAIL midrst_async outputs got %b need 010000",
               {bit_strobe_out, rx_bit_out, start_bit_out, stop_bit_out, framing_err_out, busy_out});
    end
    rx_in = 1'b1;
    repeat (3) @(negedge Clk);
    reset = 1'b0;
    @(negedge Clk);
    checks++;
    if ({bit_strobe_out, rx_bit_out, start_bit_out, stop_bit_out, framing_err_out, busy_out} !== 6'b010000) begin
      errors++;
      $display("FAIL midrst_release outputs got %b need 010000",
               {bit_strobe_out, rx_bit_out, start_bit_out, stop_bit_out, framing_err_out, busy_out});
    end
    idle(5);
    send_frame(make_bits(8'h81, 1'b0, 1'b1), -1, -1, NB * CPB);
    idle(4);
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL midrst_event_count got %0d need %0d", act_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      ev_t a;
      a = (i < act_q.size()) ? act_q[i] : '0;
      checks++;
      if (a !== exp_q[i]) begin
        errors++;
        $display("FAIL midrst_event[%0d] got cyc=%0d s/b/st/sp/fe=%b%b%b%b%b need cyc=%0d s/b/st/sp/fe=%b%b%b%b%b", i,
                 a.cyc, a.stb, a.b, a.st, a.sp, a.fe, exp_q[i].cyc, exp_q[i].stb, exp_q[i].b, exp_q[i].st,
                 exp_q[i].sp, exp_q[i].fe);
      end
    end
  endtask

  task automatic test_majority_glitch();
    exp_q.delete();
    act_q.delete();
    // One-cycle inversion exactly at the centre of data bit 3.
    send_frame(make_bits(8'h55, 1'b0, 1'b1), 4, CPB / 2, NB * CPB);
    idle(4);
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL vote_event_count got %0d need %0d", act_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      ev_t a;
      a = (i < act_q.size()) ? act_q[i] : '0;
      checks++;
      if (a !== exp_q[i]) begin
        errors++;
        $display("FAIL vote_event[%0d] got cyc=%0d s/b/st/sp/fe=%b%b%b%b%b need cyc=%0d s/b/st/sp/fe=%b%b%b%b%b", i,
                 a.cyc, a.stb, a.b, a.st, a.sp, a.fe, exp_q[i].cyc, exp_q[i].stb, exp_q[i].b, exp_q[i].st,
                 exp_q[i].sp, exp_q[i].fe);
      end
    end
  endtask

  task automatic test_random_frames();
    int offs [6];
    offs = '{2, 3, 4, 12, 13, 14};
    exp_q.delete();
    act_q.delete();
    for (int f = 0; f < 6; f++) begin
      idle($urandom_range(0, 12));
      send_frame(make_bits(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1),
                 $urandom_range(1, NB - 2), offs[$urandom_range(0, 5)], NB * CPB);
    end
    idle(4);
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_event_count got %0d need %0d", act_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      ev_t a;
      a = (i < act_q.size()) ? act_q[i] : '0;
      checks++;
      if (a !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_event[%0d] got cyc=%0d s/b/st/sp/fe=%b%b%b%b%b need cyc=%0d s/b/st/sp/fe=%b%b%b%b%b", i,
                 a.cyc, a.stb, a.b, a.st, a.sp, a.fe, exp_q[i].cyc, exp_q[i].stb, exp_q[i].b, exp_q[i].st,
                 exp_q[i].sp, exp_q[i].fe);
      end
    end
  endtask

  initial begin
    @(negedge Clk);
    test_reset();
    test_frame_a5();
    idle(7);
    test_start_glitch();
    test_framing_error();
    idle(3);
    test_back_to_back();
    idle(6);
    test_reset_mid_frame();
    idle(5);
    test_majority_glitch();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
